freq_tone_gen: RTL
==================

Name: freq_tone_gen

Overview:
- Test-signal source paired with the frequency counter.
- Takes a decimal digit 0–9 and produces a square wave on sig_o. Its toggle count per measurement window lands in the centre of that digit's counter bin, so looping sig_o back into the counter displays the same digit.
- Uses a modulo-20 phase accumulator.
- Includes a glitch-free digit-change handshake and a per-window toggle self-count for bring-up.

Parameters:
- DEPTH, 500: measurement window length in enabled clock cycles. Matches the counter's moving-average depth and sizes count_o.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  enable. When low, all state holds.
- digit_i  in  4  requested digit. Values >9 clamp to 9.
- load_i  in  1  single-cycle strobe. Captures digit_i.
- sig_o  out  1  generated square wave.
- toggle_o  out  1  registered pulse, high in each cycle in which sig_o changed.
- busy_o  out  1  high while a loaded digit waits to be applied.
- window_o  out  1  one-cycle pulse marking the last enabled cycle of each DEPTH window.
- count_o  out  $clog2(DEPTH+1)  toggles in the last completed window.

Behaviour:
- Reset asserted (reset=0): immediately clear all state.
  - Registers: acc, phase, active digit, pending digit, window counter, toggle tally.
  - Outputs: sig_o, toggle_o, busy_o, window_o and count_o all go to 0.
  - Deassertion is used synchronously (2-flop synchroniser on deassert).
- Increment: inc = 2*active+1, range 1..19.
- Registers: acc is 5 bits, range 0..19; phase is 0..19.
- Each enabled cycle:
  - s = acc + inc.
  - If s >= 20: acc <= s-20, sig_o <= ~sig_o, toggle_o <= 1.
  - Else: acc <= s, toggle_o <= 0.
  - phase increments, wrapping 19 -> 0.
- acc is exactly 0 at every phase wrap, giving 2d+1 toggles per 20 enabled cycles, strictly periodic.
- First toggle after reset:
  - d=0 toggles on the 20th enabled cycle.
  - d=9 toggles on the 2nd enabled cycle.
- en=0: acc, phase, sig_o and the window counter all hold; toggle_o=0; window_o=0.
- Load handshake:
  - load_i=1 in any cycle: pending <= min(digit_i,9) and busy_o <= 1 on the next edge.
  - A load while busy_o=1 overwrites pending; the last value wins.
- Apply point: the cycle with busy_o=1 and either (en=1 and phase=19) or en=0.
  - active <= pending; busy_o <= 0.
  - acc and phase are already 0 at the boundary, or are held when en=0.
  - The new increment is used from the next cycle.
- Load in the same cycle as the apply point: the clamped digit_i bypasses pending and is applied directly; busy_o <= 0.
- Load while idle, with en=1 and phase=19 in that cycle: pending captures, busy_o rises, and the apply occurs at the next phase=19.
- Window:
  - The window counter counts enabled cycles 0..DEPTH-1.
  - The toggle tally adds each cycle's toggle decision.
  - On an enabled cycle with counter = DEPTH-1, all in the same edge:
    - count_o <= tally + this cycle's toggle;
    - tally <= 0;
    - counter <= 0;
    - window_o <= 1.
  - Otherwise window_o <= 0.
- Width rule: count_o never exceeds DEPTH-1, so it does not overflow. Arithmetic is unsigned.
- Steady state with DEPTH a multiple of 20: count_o = (2d+1)*DEPTH/20.
- Reset asserted mid-operation: outputs go to 0 asynchronously. Any pending load is discarded.

Test Plan:
- Reset, then 30 cycles with en=0 -> all outputs 0, busy_o=0.
- Reset, en=1, default digit 0, DEPTH=500 -> sig_o period 40 cycles, first toggle at enabled cycle 20, window_o every 500 cycles, count_o=25.
- Load 9, then 4 steady, DEPTH=500 -> count_o=475 for digit 9 and 225 for digit 4. Exactly 19 and 9 toggles in every 20-cycle phase frame respectively.
- Running d=2 at phase=5, pulse load_i with 7 -> busy_o=1 for cycles phase 6..19, low after the phase=19 edge. Frames before the edge have 5 toggles; frames after have 15. No glitch at the boundary.
- Two loads while busy (3 then 12) -> applied digit is 9 (clamped, last wins). Load with en=0 -> applied on the next edge, busy_o pulses for 1 cycle.
- Drop en for 7 cycles mid-frame -> sig_o, acc, phase and window hold. Toggle sequence resumes unchanged.
- Reset pulsed mid-window -> all outputs 0 asynchronously. Pending load lost.
- After release, behaviour matches a fresh reset.

Source files
------------

// File: rtl/freq_tone_gen.sv
// Digit-controlled square-wave source for looping back into the frequency counter.
// A modulo-20 phase accumulator gives 2d+1 toggles per 20 enabled cycles; digit changes land on frame boundaries.
module freq_tone_gen #(
    parameter int DEPTH = 500
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [3:0]                 digit_i,
    input  logic                       load_i,
    output logic                       sig_o,
    output logic                       toggle_o,
    output logic                       busy_o,
    output logic                       window_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    rst_sync;
    logic          rst_n;

    logic [4:0]    acc;
    logic [4:0]    phase;
    logic [3:0]    active;
    logic [3:0]    pending;
    logic [WW-1:0] win_cnt;
    logic [CW-1:0] tally;

    logic [4:0]    inc;
    logic [5:0]    sum;
    logic          hit;
    logic [4:0]    acc_next;
    logic          phase_last;
    logic          win_last;
    logic          apply;
    logic [3:0]    digit_clamped;

    // NOTE: reset asserts asynchronously but releases only after two clock edges,
    // so every state flop leaves reset in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        inc           = {active, 1'b1};
        sum           = {1'b0, acc} + {1'b0, inc};
        hit           = (sum >= 6'd20);
        acc_next      = hit ? 5'(sum - 6'd20) : sum[4:0];
        phase_last    = (phase == 5'd19);
        win_last      = (win_cnt == WW'(DEPTH - 1));
        apply         = busy_o && (!en || phase_last);
        digit_clamped = (digit_i > 4'd9) ? 4'd9 : digit_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            phase    <= '0;
            active   <= '0;
            pending  <= '0;
            win_cnt  <= '0;
            tally    <= '0;
            sig_o    <= 1'b0;
            toggle_o <= 1'b0;
            busy_o   <= 1'b0;
            window_o <= 1'b0;
            count_o  <= '0;
        end else begin
            if (en) begin
                acc      <= acc_next;
                toggle_o <= hit;
                if (hit) begin
                    sig_o <= ~sig_o;
                end
                phase <= phase_last ? 5'd0 : phase + 5'd1;

                if (win_last) begin
                    count_o  <= tally + CW'(hit);
                    tally    <= '0;
                    win_cnt  <= '0;
                    window_o <= 1'b1;
                end else begin
                    tally    <= tally + CW'(hit);
                    win_cnt  <= win_cnt + WW'(1);
                    window_o <= 1'b0;
                end
            end else begin
                toggle_o <= 1'b0;
                window_o <= 1'b0;
            end

            // A load coinciding with the apply point skips the pending register.
            if (apply) begin
                active <= load_i ? digit_clamped : pending;
                busy_o <= 1'b0;
            end else if (load_i) begin
                pending <= digit_clamped;
                busy_o  <= 1'b1;
            end
        end
    end

endmodule
